ram_data_arbiter: RTL and testbench
===================================

Name: ram_data_arbiter

Overview:
- Arbitrates the single data port of the shared instruction/data RAM between the Ibex LSU and the UART loader/debug master.
- Provides fair round-robin arbitration, a UART burst lock with Ibex starvation protection, and per-requester response routing.
- Response routing sends rvalid/rdata only to the master that issued the access.
- Sits between both masters and the RAM's port B; the instruction port is not touched.

Parameters:
- ADDR_WIDTH, 12, word address width of the RAM data port.
- STARVE_LIMIT, 8, number of consecutive ungranted Ibex request cycles that forces an Ibex grant; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ibex_req_i / uart_req_i  in  1  access request
- ibex_addr_i / uart_addr_i  in  ADDR_WIDTH  word address
- ibex_we_i / uart_we_i  in  1  write enable
- ibex_be_i / uart_be_i  in  4  byte enables
- ibex_wdata_i / uart_wdata_i  in  32  write data
- ibex_gnt_o / uart_gnt_o  out  1  request accepted this cycle
- ibex_rvalid_o / uart_rvalid_o  out  1  response valid (reads and writes)
- ibex_rdata_o / uart_rdata_o  out  32  read data
- uart_lock_i  in  1  UART requests exclusive ownership for a burst
- ram_req_o  out  1  RAM port B enable
- ram_addr_o  out  ADDR_WIDTH  RAM port B address
- ram_we_o  out  1  RAM port B write enable
- ram_be_o  out  4  RAM port B byte enables
- ram_wdata_o  out  32  RAM port B write data
- ram_rdata_i  in  32  RAM port B read data, valid one cycle after ram_req_o
- locked_o  out  1  arbiter is in LOCKED state

Behaviour:
- Grant is combinational, in the same cycle as the request.
- At most one gnt per cycle. ram_req_o = ibex_gnt_o | uart_gnt_o.
- ram_addr/we/be/wdata are muxed from the granted master; when neither is granted they hold the Ibex inputs and ram_req_o is 0.
- A master is only granted while its req is high. Dropping req before gnt is legal and has no side effects.
- All gnt outputs are forced to 0 while rst is high.
- State machine, two states, reset state UNLOCKED:
  - UNLOCKED: single requester wins. With both requesting, the master not granted last wins (last_grant register; reset value = UART, so Ibex wins the first tie).
  - UNLOCKED -> LOCKED: on a cycle with uart_gnt_o=1 and uart_lock_i=1.
  - LOCKED: UART wins whenever it requests; Ibex is granted only when UART is not requesting, or by the starvation rule.
  - LOCKED -> UNLOCKED: on the first cycle uart_lock_i=0. The arbitration decision in that cycle already uses UNLOCKED rules.
- Starvation counter (8 bit, reset 0):
  - Increments on each cycle ibex_req_i=1 with ibex_gnt_o=0, saturating at STARVE_LIMIT.
  - Clears on ibex_gnt_o or when ibex_req_i=0.
  - When the counter equals STARVE_LIMIT, Ibex wins in any state. The state stays LOCKED.
- last_grant updates on every grant.
- Responses:
  - A registered pending flag and owner id are captured on each grant.
  - The owner's rvalid is asserted exactly one cycle after its gnt, for one cycle, with rdata_o = ram_rdata_i. The other master sees rvalid=0 and rdata=0.
  - Back-to-back grants yield back-to-back rvalids in grant order.
- Reset values: all gnt, rvalid and rdata outputs 0; ram_req_o 0; locked_o 0; pending 0; counter 0.
- Reset asserted with a response pending discards that response: no rvalid in the following cycle.

Test Plan:
1. Ibex-only read: ibex_req=1, addr=0x010 for one cycle -> ibex_gnt=1 and ram_req=1 in the same cycle; ibex_rvalid=1 next cycle with ibex_rdata = ram_rdata_i (0xDEADBEEF); uart_rvalid=0 throughout.
2. Both request continuously after reset, lock=0 -> grants alternate Ibex, UART, Ibex, UART; rvalids follow one cycle later in the same order, each with the matching rdata.
3. UART asserts lock and requests continuously, Ibex requests continuously, STARVE_LIMIT=8:
   - locked_o=1 from the cycle after the first UART grant.
   - Ibex is granted on the 9th cycle of waiting, then UART resumes.
   - The pattern repeats every 9 cycles.
4. Lock release: uart_lock_i falls while both request -> locked_o=0 and round-robin resumes in that same cycle; Ibex wins if UART was granted last.
5. UART write (be=4'b0011, wdata=0x1234ABCD): ram_we=1 and ram_be=0011 in the grant cycle; uart_rvalid=1 next cycle; ibex_gnt=0 in that grant cycle.
6. Reset mid-transaction: grant an Ibex read, assert rst in the next cycle -> ibex_rvalid=0 and all gnt=0 while rst is high. After release, state is UNLOCKED, counter 0, and Ibex wins the first tie.

Source files
------------

// File: rtl/ram_data_arbiter.sv
// Data-port arbiter for the shared instruction/data RAM: Ibex LSU vs UART loader.
// Round-robin with a UART burst lock, Ibex starvation guard and per-master response routing.
module ram_data_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ibex_req_i,
  input  logic [ADDR_WIDTH-1:0] ibex_addr_i,
  input  logic                  ibex_we_i,
  input  logic [3:0]            ibex_be_i,
  input  logic [31:0]           ibex_wdata_i,
  output logic                  ibex_gnt_o,
  output logic                  ibex_rvalid_o,
  output logic [31:0]           ibex_rdata_o,
  input  logic                  uart_req_i,
  input  logic [ADDR_WIDTH-1:0] uart_addr_i,
  input  logic                  uart_we_i,
  input  logic [3:0]            uart_be_i,
  input  logic [31:0]           uart_wdata_i,
  output logic                  uart_gnt_o,
  output logic                  uart_rvalid_o,
  output logic [31:0]           uart_rdata_o,
  input  logic                  uart_lock_i,
  output logic                  ram_req_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic                  locked_o
);

  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {UNLOCKED, LOCKED} state_t;
  typedef enum logic {OWN_IBEX, OWN_UART} owner_t;

  state_t           state_q;
  owner_t           last_grant_q;
  owner_t           owner_q;
  logic             pending_q;
  logic [CNT_W-1:0] starve_q;

  logic lock_eff;
  logic starved;
  logic ibex_win;
  logic uart_win;

  // Lock release takes effect in the same cycle uart_lock_i drops.
  assign lock_eff = (state_q == LOCKED) && uart_lock_i;
  assign starved  = ibex_req_i && (starve_q == STARVE_MAX);

  always_comb begin
    ibex_win = 1'b0;
    uart_win = 1'b0;
    if (!rst) begin
      if (starved) begin
        ibex_win = 1'b1;
      end else if (lock_eff) begin
        if (uart_req_i) uart_win = 1'b1;
        else            ibex_win = ibex_req_i;
      end else if (ibex_req_i && uart_req_i) begin
        if (last_grant_q == OWN_UART) ibex_win = 1'b1;
        else                          uart_win = 1'b1;
      end else begin
        ibex_win = ibex_req_i;
        uart_win = uart_req_i;
      end
    end
  end

  assign ibex_gnt_o = ibex_win;
  assign uart_gnt_o = uart_win;
  assign ram_req_o  = ibex_win | uart_win;

  // Idle port presents the Ibex request fields.
  assign ram_addr_o  = uart_win ? uart_addr_i  : ibex_addr_i;
  assign ram_we_o    = uart_win ? uart_we_i    : ibex_we_i;
  assign ram_be_o    = uart_win ? uart_be_i    : ibex_be_i;
  assign ram_wdata_o = uart_win ? uart_wdata_i : ibex_wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      last_grant_q <= OWN_UART;
      owner_q      <= OWN_IBEX;
      pending_q    <= 1'b0;
      starve_q     <= '0;
    end else begin
      case (state_q)
        UNLOCKED: if (uart_win && uart_lock_i) state_q <= LOCKED;
        LOCKED:   if (!uart_lock_i)            state_q <= UNLOCKED;
        default:                               state_q <= UNLOCKED;
      endcase

      if (ibex_win)      last_grant_q <= OWN_IBEX;
      else if (uart_win) last_grant_q <= OWN_UART;

      if (!ibex_req_i || ibex_win)   starve_q <= '0;
      else if (starve_q != STARVE_MAX) starve_q <= starve_q + CNT_W'(1);

      pending_q <= ibex_win | uart_win;
      if (ibex_win)      owner_q <= OWN_IBEX;
      else if (uart_win) owner_q <= OWN_UART;
    end
  end

  // A response still pending when reset arrives is dropped.
  assign ibex_rvalid_o = pending_q && (owner_q == OWN_IBEX) && !rst;
  assign uart_rvalid_o = pending_q && (owner_q == OWN_UART) && !rst;
  assign ibex_rdata_o  = ibex_rvalid_o ? ram_rdata_i : 32'h0;
  assign uart_rdata_o  = uart_rvalid_o ? ram_rdata_i : 32'h0;
  assign locked_o      = lock_eff && !rst;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Self-checking bench for ram_data_arbiter: grant checks inline per scenario,
// responses checked by a scoreboard monitor against expected owner and data.
module tb_ram_data_arbiter;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ibex_req = 1'b0, uart_req = 1'b0, uart_lock = 1'b0;
  logic [AW-1:0] ibex_addr = '0, uart_addr = '0;
  logic          ibex_we = 1'b0, uart_we = 1'b0;
  logic [3:0]    ibex_be = 4'hF, uart_be = 4'hF;
  logic [31:0]   ibex_wdata = 32'h11111111, uart_wdata = 32'h22222222;
  logic          ibex_gnt, uart_gnt, ibex_rvalid, uart_rvalid;
  logic [31:0]   ibex_rdata, uart_rdata;
  logic          ram_req, ram_we, locked;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    bit          uart;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  ram_data_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .ibex_req_i(ibex_req), .ibex_addr_i(ibex_addr), .ibex_we_i(ibex_we),
    .ibex_be_i(ibex_be), .ibex_wdata_i(ibex_wdata), .ibex_gnt_o(ibex_gnt),
    .ibex_rvalid_o(ibex_rvalid), .ibex_rdata_o(ibex_rdata),
    .uart_req_i(uart_req), .uart_addr_i(uart_addr), .uart_we_i(uart_we),
    .uart_be_i(uart_be), .uart_wdata_i(uart_wdata), .uart_gnt_o(uart_gnt),
    .uart_rvalid_o(uart_rvalid), .uart_rdata_o(uart_rdata),
    .uart_lock_i(uart_lock),
    .ram_req_o(ram_req), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .locked_o(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hC0DE0, a};
  endfunction

  // RAM port B model: data for the presented address appears one cycle later.
  always @(posedge clk) if (ram_req) ram_rdata <= ram_word(ram_addr);

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic iw,
                       input logic ur, input logic [AW-1:0] ua, input logic uw,
                       input logic lk);
    @(negedge clk);
    rst = 1'b0;
    ibex_req = ir; ibex_addr = ia; ibex_we = iw;
    uart_req = ur; uart_addr = ua; uart_we = uw;
    uart_lock = lk;
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, '0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
        tests++; fails++;
        $display("FAIL missing_rvalid: grant cycle %0d got no rvalid, required %s rvalid",
                 sb[0].cyc, sb[0].uart ? "uart" : "ibex");
        void'(sb.pop_front());
      end
      if (ibex_rvalid || uart_rvalid) begin
        tests++;
        if (sb.size() == 0 || sb[0].cyc + 1 != cyc) begin
          fails++;
          $display("FAIL unexpected_rvalid: cycle %0d got ibex=%0b uart=%0b, required none",
                   cyc, ibex_rvalid, uart_rvalid);
        end else begin
          e = sb.pop_front();
          if (ibex_rvalid !== !e.uart || uart_rvalid !== e.uart ||
              (e.uart ? uart_rdata : ibex_rdata) !== e.data ||
              (e.uart ? ibex_rdata : uart_rdata) !== 32'h0) begin
            fails++;
            $display("FAIL response: cycle %0d got ibex_rv=%0b/%h uart_rv=%0b/%h, required %s data %h",
                     cyc, ibex_rvalid, ibex_rdata, uart_rvalid, uart_rdata,
                     e.uart ? "uart" : "ibex", e.data);
          end
        end
      end else begin
        tests++;
        if (ibex_rdata !== 32'h0 || uart_rdata !== 32'h0) begin
          fails++;
          $display("FAIL idle_rdata: got ibex=%h uart=%h, required 0", ibex_rdata, uart_rdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ibex_req = 1'b1; uart_req = 1'b1; uart_lock = 1'b1;
    #1;
    tests++;
    if ({ibex_gnt, uart_gnt, ram_req, locked, ibex_rvalid, uart_rvalid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got gnt=%b%b req=%b lock=%b rv=%b%b, required all 0",
               ibex_gnt, uart_gnt, ram_req, locked, ibex_rvalid, uart_rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_idle();
    drive(0, 12'h3C4, 0, 0, 12'h055, 0, 0);
    tests++;
    if (ibex_gnt !== 1'b0 || uart_gnt !== 1'b0 || ram_req !== 1'b0 || ram_addr !== 12'h3C4) begin
      fails++;
      $display("FAIL idle: got gnt=%b%b req=%b addr=%h, required 0 0 0 3c4",
               ibex_gnt, uart_gnt, ram_req, ram_addr);
    end
  endtask

  task automatic test_ibex_read();
    drive(1, 12'h010, 0, 0, 12'h777, 0, 0);
    tests++;
    if (ibex_gnt !== 1'b1 || uart_gnt !== 1'b0 || ram_req !== 1'b1 || ram_addr !== 12'h010 ||
        ram_we !== 1'b0) begin
      fails++;
      $display("FAIL ibex_read_gnt: got gnt=%b%b req=%b addr=%h we=%b, required 1 0 1 010 0",
               ibex_gnt, uart_gnt, ram_req, ram_addr, ram_we);
    end
    sb.push_back('{cyc, 1'b0, 32'hDEADBEEF});
    drive(0, 12'h010, 0, 0, 12'h777, 0, 0);
    tests++;
    if (ibex_rvalid !== 1'b1 || ibex_rdata !== 32'hDEADBEEF || uart_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL ibex_read_rsp: got rv=%b data=%h uart_rv=%b, required 1 deadbeef 0",
               ibex_rvalid, ibex_rdata, uart_rvalid);
    end
  endtask

  task automatic test_round_robin();
    bit exp_u;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_u = (i % 2) == 1;
      drive(1, AW'(12'h100 + i), 0, 1, AW'(12'h200 + i), 0, 0);
      tests++;
      if (ibex_gnt !== !exp_u || uart_gnt !== exp_u || ram_addr !== (exp_u ? AW'(12'h200 + i) : AW'(12'h100 + i))) begin
        fails++;
        $display("FAIL round_robin[%0d]: got gnt=%b%b addr=%h, required ibex=%b uart=%b",
                 i, ibex_gnt, uart_gnt, ram_addr, !exp_u, exp_u);
      end
      sb.push_back('{cyc, exp_u, ram_word(exp_u ? AW'(12'h200 + i) : AW'(12'h100 + i))});
    end
    drive(0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic test_lock_starve();
    bit exp_i;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp_i = (i % 9) == 0;
      drive(1, AW'(12'h300 + i), 0, 1, AW'(12'h400 + i), 0, 1);
      tests++;
      if (ibex_gnt !== exp_i || uart_gnt !== !exp_i || locked !== (i >= 2)) begin
        fails++;
        $display("FAIL lock_starve[%0d]: got gnt=%b%b locked=%b, required ibex=%b uart=%b locked=%b",
                 i, ibex_gnt, uart_gnt, locked, exp_i, !exp_i, i >= 2);
      end
      sb.push_back('{cyc, !exp_i, ram_word(exp_i ? AW'(12'h300 + i) : AW'(12'h400 + i))});
    end
  endtask

  task automatic test_lock_release();
    bit exp_u;
    for (int i = 0; i < 4; i++) begin
      exp_u = (i % 2) == 1;
      drive(1, AW'(12'h500 + i), 0, 1, AW'(12'h600 + i), 0, 0);
      tests++;
      if (ibex_gnt !== !exp_u || uart_gnt !== exp_u || locked !== 1'b0) begin
        fails++;
        $display("FAIL lock_release[%0d]: got gnt=%b%b locked=%b, required ibex=%b uart=%b locked=0",
                 i, ibex_gnt, uart_gnt, locked, !exp_u, exp_u);
      end
      sb.push_back('{cyc, exp_u, ram_word(exp_u ? AW'(12'h600 + i) : AW'(12'h500 + i))});
    end
    drive(0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic test_uart_write();
    uart_be = 4'b0011;
    uart_wdata = 32'h1234ABCD;
    drive(0, 12'h0F0, 0, 1, 12'h0AB, 1, 0);
    tests++;
    if (uart_gnt !== 1'b1 || ibex_gnt !== 1'b0 || ram_we !== 1'b1 || ram_be !== 4'b0011 ||
        ram_wdata !== 32'h1234ABCD || ram_addr !== 12'h0AB) begin
      fails++;
      $display("FAIL uart_write: got gnt=%b%b we=%b be=%b wdata=%h addr=%h, required 0 1 1 0011 1234abcd 0ab",
               ibex_gnt, uart_gnt, ram_we, ram_be, ram_wdata, ram_addr);
    end
    sb.push_back('{cyc, 1'b1, ram_word(12'h0AB)});
    drive(0, '0, 0, 0, '0, 0, 0);
    tests++;
    if (uart_rvalid !== 1'b1 || ibex_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL uart_write_rsp: got uart_rv=%b ibex_rv=%b, required 1 0", uart_rvalid, ibex_rvalid);
    end
    uart_be = 4'hF;
    uart_wdata = 32'h22222222;
  endtask

  task automatic test_reset_mid();
    drive(1, 12'h020, 0, 0, 12'h030, 0, 0);
    tests++;
    if (ibex_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_gnt: got ibex_gnt=%b, required 1", ibex_gnt);
    end
    @(negedge clk);
    rst = 1'b1; uart_req = 1'b1; uart_lock = 1'b1;
    #1;
    tests++;
    if (ibex_rvalid !== 1'b0 || ibex_gnt !== 1'b0 || uart_gnt !== 1'b0 || ram_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got rv=%b gnt=%b%b req=%b, required 0 0 0 0",
               ibex_rvalid, ibex_gnt, uart_gnt, ram_req);
    end
    drive(1, 12'h021, 0, 1, 12'h031, 0, 0);
    tests++;
    if (ibex_gnt !== 1'b1 || uart_gnt !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_tie: got gnt=%b%b locked=%b, required 1 0 0",
               ibex_gnt, uart_gnt, locked);
    end
    sb.push_back('{cyc, 1'b0, ram_word(12'h021)});
    drive(0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_idle();
    test_ibex_read();
    test_round_robin();
    test_lock_starve();
    test_lock_release();
    test_uart_write();
    test_reset_mid();
    repeat (3) drive(0, '0, 0, 0, '0, 0, 0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
